// File: rtl/wire_alu_pkg.sv
// Shared constants for the multi-channel wire-in ALU bank:
// operation codes and FSM state encoding.
package wire_alu_pkg;

   localparam logic [1:0] MODE_ADD = 2'd0;
   localparam logic [1:0] MODE_SUB = 2'd1;
   localparam logic [1:0] MODE_ACC = 2'd2;
   localparam logic [1:0] MODE_CLR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/wire_alu_bank_if.sv
// Host-side bundle of the ALU bank: trigger, mode, operands
// in; results, flags, status and run counter out.
interface wire_alu_bank_if #(
   parameter int WIDTH = 16,
   parameter int NCH   = 4
);

   logic                   start;
   logic [1:0]             mode;
   logic [NCH*WIDTH-1:0]   op_a;
   logic [NCH*WIDTH-1:0]   op_b;
   logic [NCH*WIDTH-1:0]   result;
   logic [NCH-1:0]         flags;
   logic                   busy;
   logic                   done;
   logic [15:0]            run_count;

   modport master (
      output start, mode, op_a, op_b,
      input  result, flags, busy, done, run_count
   );

   modport slave (
      input  start, mode, op_a, op_b,
      output result, flags, busy, done, run_count
   );

endinterface

// File: rtl/wire_alu_core.sv
// Single-channel combinational ALU datapath, time-shared by the bank.
// WIRE_ALU_SAT_EN selects saturating instead of modular results.
module wire_alu_core
   import wire_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] r_old,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] r_new,
   output logic             flag
);

   logic [WIDTH:0] s;

   always_comb begin
      s     = '0;
      r_new = '0;
      flag  = 1'b0;
      unique case (mode)
         MODE_ADD: s = {1'b0, a} + {1'b0, b};
         MODE_SUB: s = {1'b0, a} - {1'b0, b};
         MODE_ACC: s = {1'b0, r_old} + {1'b0, a};
         default:  s = '0;
      endcase
      // Top bit is carry for ADD/ACC and borrow (a<b) for SUB
      flag  = s[WIDTH];
      r_new = s[WIDTH-1:0];
`ifdef WIRE_ALU_SAT_EN
      if (flag)
         r_new = (mode == MODE_SUB) ? '0 : '1;
`endif
   end

endmodule

// File: rtl/wire_alu_bank.sv
// Multi-channel registered ALU bank: snapshots inputs on start and
// processes one channel per ti_clk. Optional macro: WIRE_ALU_SAT_EN.
module wire_alu_bank
   import wire_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NCH   = 4
) (
   input  logic            ti_clk,
   input  logic            reset,
   wire_alu_bank_if.slave  bus
);

   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

   state_t               state_q;
   state_t               state_d;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     idx_d;
   logic                 last;

   logic [NCH*WIDTH-1:0] snap_a;
   logic [NCH*WIDTH-1:0] snap_b;
   logic [1:0]           snap_mode;

   logic [WIDTH-1:0]     a_arr [NCH];
   logic [WIDTH-1:0]     b_arr [NCH];
   logic [WIDTH-1:0]     res_q [NCH];
   logic [NCH-1:0]       flags_q;
   logic [15:0]          count_q;

   logic [WIDTH-1:0]     r_new;
   logic                 flag_new;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign a_arr[c] = snap_a[c*WIDTH +: WIDTH];
      assign b_arr[c] = snap_b[c*WIDTH +: WIDTH];
      assign bus.result[c*WIDTH +: WIDTH] = res_q[c];
   end

   assign bus.flags     = flags_q;
   assign bus.run_count = count_q;
   assign bus.busy      = (state_q == ST_RUN);
   assign bus.done      = (state_q == ST_DONE);

   assign last = (idx_q == IDX_W'(NCH - 1));

   wire_alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (a_arr[idx_q]),
      .b     (b_arr[idx_q]),
      .r_old (res_q[idx_q]),
      .mode  (snap_mode),
      .r_new (r_new),
      .flag  (flag_new)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               idx_d   = '0;
            end
         end
         ST_RUN: begin
            if (last) begin
               state_d = ST_DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ti_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Start is only honoured in IDLE; later pulses are dropped, not queued
   always_ff @(posedge ti_clk) begin
      if (reset) begin
         snap_a    <= '0;
         snap_b    <= '0;
         snap_mode <= '0;
         flags_q   <= '0;
         count_q   <= '0;
         for (int c = 0; c < NCH; c++)
            res_q[c] <= '0;
      end else begin
         if (state_q == ST_IDLE && bus.start) begin
            snap_a    <= bus.op_a;
            snap_b    <= bus.op_b;
            snap_mode <= bus.mode;
         end
         if (state_q == ST_RUN) begin
            res_q[idx_q]   <= r_new;
            flags_q[idx_q] <= flag_new;
         end
         if (state_q == ST_DONE)
            count_q <= count_q + 16'd1;
      end
   end

endmodule
